// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the serial add/subtract sequencer.
package serial_add_ctrl_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/select8.sv
// 8-bit carry-select adder slice: ripple low nibble, high nibble precomputed for both carries.
module select8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  assign lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, ci};
  assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
  assign hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

  assign s  = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
  assign co = lo[4] ? hi1[4] : hi0[4];

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-byte add/subtract sequencer: one select8 slice processes the operands LSB byte first.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op_sub,
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned CntW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]   a_sh_q, a_sh_d;
  logic [W-1:0]   b_sh_q, b_sh_d;
  logic [W-1:0]   res_sh_q, res_sh_d;
  logic           carry_q, carry_d;
  logic           a_msb_q, a_msb_d;
  logic           b_msb_q, b_msb_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic [7:0]     slice_s;
  logic           slice_co;

  select8 u_slice (
    .a  (a_sh_q[7:0]),
    .b  (b_sh_q[7:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          a_sh_d  = a;
          // Subtract is A + ~B + 1, so the inverted operand and forced carry carry the op.
          b_sh_d  = op_sub ? ~b : b;
          carry_d = op_sub ? 1'b1 : cin;
          a_msb_d = a[W-1];
          b_msb_d = op_sub ? ~b[W-1] : b[W-1];
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_sh_d   = a_sh_q >> ByteW;
        b_sh_d   = b_sh_q >> ByteW;
        res_sh_d = {slice_s, res_sh_q[W-1:ByteW]};
        carry_d  = slice_co;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NBYTES - 1)) begin
          state_d = StDone;
          sum_d   = {slice_s, res_sh_q[W-1:ByteW]};
          cout_d  = slice_co;
          ovf_d   = (a_msb_q == b_msb_q) & (slice_s[7] != a_msb_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready = (state_q != StRun);
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op_sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;

  serial_add_ctrl #(.NBYTES(NBYTES)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sub (op_sub),
    .cin    (cin),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow by range check.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic op,
                       input logic ci, output logic [W-1:0] s, output logic co,
                       output logic ov);
    longint unsigned u;
    longint          sa;
    longint          sb;
    longint          r;
    sa = $signed(ta);
    sb = $signed(tb);
    if (!op) begin
      u  = 64'(ta) + 64'(tb) + 64'(ci);
      s  = u[W-1:0];
      co = u[W];
      r  = sa + sb + longint'(ci);
    end else begin
      s  = ta - tb;
      co = (ta >= tb);
      r  = sa - sb;
    end
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endtask

  // Called #1 after an edge with ready=1; returns #1 after the done edge.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic op,
                        input logic ci, input string tag, input bit poke);
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    logic [W-1:0] prev;
    int           lat;
    model(ta, tb, op, ci, es, ec, eo);
    prev   = sum;
    a      = ta;
    b      = tb;
    op_sub = op;
    cin    = ci;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    while (!done && lat < NBYTES + 4) begin
      chk({tag, "_hold"}, 64'(sum), 64'(prev));
      a      = $urandom;
      b      = $urandom;
      op_sub = 1'($urandom);
      cin    = 1'($urandom);
      start  = poke && (lat == 2);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 64'(lat), 64'(NBYTES + 1));
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_sum"}, 64'(sum), 64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    op_sub = 1'b0;
    cin    = 1'b0;
    a      = '0;
    b      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "wrap_add", 1'b0);
    @(posedge clk); #1;
    chk("after_done_idle", 64'(done), 64'd0);
    chk("idle_ready", 64'(ready), 64'd1);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, "borrow_sub", 1'b0);
    @(posedge clk); #1;
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "ovf_add", 1'b0);
    @(posedge clk); #1;
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, "ovf_sub", 1'b0);
    @(posedge clk); #1;
    run_op(32'h1234_00FF, 32'h0000_0000, 1'b0, 1'b1, "cin_prop", 1'b1);
    // Start in the DONE cycle is accepted immediately.
    run_op(32'd5, 32'd3, 1'b0, 1'b0, "b2b", 1'b0);

    // Reset in the second RUN cycle abandons the operation.
    a     = 32'h0101_0101;
    b     = 32'h0202_0202;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    for (int i = 0; i < NBYTES + 2; i++) begin
      chk("midrst_nodone", 64'(done), 64'd0);
      @(posedge clk); #1;
    end
    run_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, "post_rst", 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        chk("rnd_gap_done", 64'(done), 64'd0);
      end
      run_op($urandom, $urandom, 1'($urandom), 1'($urandom), "rnd", bit'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
